// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: two one-entry writeback slots (A = execute,
// B = load) arbitrated onto a single write port, plus a pending-write scoreboard
// that reports and forwards in-flight data for two read addresses.
module rf_write_scheduler #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              rs1_pend,
  output logic [XLEN-1:0]   rs1_fwd,
  output logic              rs2_pend,
  output logic [XLEN-1:0]   rs2_fwd
);

  // Slot state. Age counts cycles a slot has been waiting and saturates; a slot
  // never waits more than two cycles, so saturation never hides an ordering.
  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_rd_q, a_rd_d;
  logic [XLEN-1:0]   a_data_q, a_data_d;
  logic [1:0]        a_age_q, a_age_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_rd_q, b_rd_d;
  logic [XLEN-1:0]   b_data_q, b_data_d;
  logic [1:0]        b_age_q, b_age_d;
  logic              rr_q, rr_d;

  logic both_full, same_rd, a_older;
  logic grant_a, grant_b;
  logic a_fill, b_fill;
  logic a_m1, b_m1, a_m2, b_m2;

  // Arbitration: single slot wins outright; same-rd pairs drain oldest first so
  // the register file sees writes in program order; otherwise round-robin.
  always_comb begin
    both_full = a_full_q && b_full_q;
    same_rd   = (a_rd_q == b_rd_q);
    a_older   = (a_age_q >= b_age_q);
    grant_a   = a_full_q && (!b_full_q || (same_rd ? a_older : !rr_q));
    grant_b   = b_full_q && !grant_a;
  end

  // Write port and handshake outputs, all derived from registered slot state.
  always_comb begin
    wr_en   = grant_a || grant_b;
    wr_rd   = '0;
    wr_data = '0;
    if (grant_a) begin
      wr_rd   = a_rd_q;
      wr_data = a_data_q;
    end else if (grant_b) begin
      wr_rd   = b_rd_q;
      wr_data = b_data_q;
    end
    a_ready = !reset && (!a_full_q || grant_a);
    b_ready = !reset && (!b_full_q || grant_b);
  end

  // Scoreboard: x0 never matches; with two hits the younger slot's data wins.
  always_comb begin
    a_m1 = a_full_q && (a_rd_q == q_rs1) && (q_rs1 != '0);
    b_m1 = b_full_q && (b_rd_q == q_rs1) && (q_rs1 != '0);
    a_m2 = a_full_q && (a_rd_q == q_rs2) && (q_rs2 != '0);
    b_m2 = b_full_q && (b_rd_q == q_rs2) && (q_rs2 != '0);
    rs1_pend = a_m1 || b_m1;
    rs2_pend = a_m2 || b_m2;
    rs1_fwd  = '0;
    rs2_fwd  = '0;
    if (a_m1 && b_m1) rs1_fwd = a_older ? b_data_q : a_data_q;
    else if (a_m1)    rs1_fwd = a_data_q;
    else if (b_m1)    rs1_fwd = b_data_q;
    if (a_m2 && b_m2) rs2_fwd = a_older ? b_data_q : a_data_q;
    else if (a_m2)    rs2_fwd = a_data_q;
    else if (b_m2)    rs2_fwd = b_data_q;
  end

  // Next slot state: drain on grant, fill on transfer (x0 transfers are dropped).
  always_comb begin
    a_fill   = a_valid && a_ready && (a_rd != '0);
    b_fill   = b_valid && b_ready && (b_rd != '0);
    a_full_d = a_full_q;
    a_rd_d   = a_rd_q;
    a_data_d = a_data_q;
    a_age_d  = a_age_q;
    b_full_d = b_full_q;
    b_rd_d   = b_rd_q;
    b_data_d = b_data_q;
    b_age_d  = b_age_q;
    if (grant_a) begin
      a_full_d = 1'b0;
      a_age_d  = '0;
    end else if (a_full_q && (a_age_q != 2'd3)) begin
      a_age_d  = a_age_q + 2'd1;
    end
    if (grant_b) begin
      b_full_d = 1'b0;
      b_age_d  = '0;
    end else if (b_full_q && (b_age_q != 2'd3)) begin
      b_age_d  = b_age_q + 2'd1;
    end
    if (a_fill) begin
      a_full_d = 1'b1;
      a_rd_d   = a_rd;
      a_data_d = a_data;
      a_age_d  = '0;
    end
    if (b_fill) begin
      b_full_d = 1'b1;
      b_rd_d   = b_rd;
      b_data_d = b_data;
      b_age_d  = '0;
    end
    rr_d = (both_full && !same_rd) ? !rr_q : rr_q;
  end

  // State registers; reset discards pending data without issuing a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_full_q <= 1'b0;
      a_rd_q   <= '0;
      a_data_q <= '0;
      a_age_q  <= '0;
      b_full_q <= 1'b0;
      b_rd_q   <= '0;
      b_data_q <= '0;
      b_age_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      a_full_q <= a_full_d;
      a_rd_q   <= a_rd_d;
      a_data_q <= a_data_d;
      a_age_q  <= a_age_d;
      b_full_q <= b_full_d;
      b_rd_q   <= b_rd_d;
      b_data_q <= b_data_d;
      b_age_q  <= b_age_d;
      rr_q     <= rr_d;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed vector table, a hand-written reset
// sequence, then random traffic against a fill-timestamp reference model.
module tb_rf_write_scheduler;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [ADDR_W-1:0] a_rd, b_rd, wr_rd, q_rs1, q_rs2;
  logic [XLEN-1:0]   a_data, b_data, wr_data, rs1_fwd, rs2_fwd;
  logic              wr_en, rs1_pend, rs2_pend;

  int total = 0;
  int bad   = 0;

  rf_write_scheduler #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .rs1_pend(rs1_pend), .rs1_fwd(rs1_fwd), .rs2_pend(rs2_pend), .rs2_fwd(rs2_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] ard;
    logic [XLEN-1:0]   adat;
    logic              bv;
    logic [ADDR_W-1:0] brd;
    logic [XLEN-1:0]   bdat;
    logic [ADDR_W-1:0] q1;
    logic [ADDR_W-1:0] q2;
    logic              e_wen;
    logic [ADDR_W-1:0] e_wrd;
    logic [XLEN-1:0]   e_wdat;
    logic              e_ardy;
    logic              e_brdy;
    logic              e_p1;
    logic [XLEN-1:0]   e_f1;
    logic              e_p2;
    logic [XLEN-1:0]   e_f2;
  } vec_t;

  vec_t vecs[21];

  // Reference model: slots tagged with the cycle number they were filled in.
  logic              ma_full, mb_full, m_rr;
  logic [ADDR_W-1:0] ma_rd, mb_rd;
  logic [XLEN-1:0]   ma_data, mb_data;
  int                ma_stamp, mb_stamp, m_cyc;

  task automatic model_clear();
    ma_full = 0; mb_full = 0; m_rr = 0;
    ma_rd = '0; mb_rd = '0; ma_data = '0; mb_data = '0;
    ma_stamp = 0; mb_stamp = 0;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] q, output logic p, output logic [XLEN-1:0] f);
    logic ha, hb;
    ha = ma_full && (ma_rd == q) && (q != 0);
    hb = mb_full && (mb_rd == q) && (q != 0);
    p = ha || hb;
    f = '0;
    if (ha && hb) f = (mb_stamp >= ma_stamp) ? mb_data : ma_data;
    else if (ha)  f = ma_data;
    else if (hb)  f = mb_data;
  endtask

  // Checks current outputs against the model, then advances the model across the edge.
  task automatic model_step();
    int g;
    logic ea, eb, p1, p2;
    logic [XLEN-1:0] f1, f2;
    if (reset) begin
      chk("rst_wr_en", {31'b0, wr_en}, 0);
      chk("rst_a_ready", {31'b0, a_ready}, 0);
      chk("rst_b_ready", {31'b0, b_ready}, 0);
      chk("rst_rs1_pend", {31'b0, rs1_pend}, 0);
      model_clear();
      m_cyc++;
      return;
    end
    g = 0;
    if (ma_full && mb_full) begin
      if (ma_rd == mb_rd) g = (ma_stamp <= mb_stamp) ? 1 : 2;
      else begin
        g = m_rr ? 2 : 1;
        m_rr = !m_rr;
      end
    end else if (ma_full) g = 1;
    else if (mb_full) g = 2;
    ea = !ma_full || (g == 1);
    eb = !mb_full || (g == 2);
    chk("wr_en", {31'b0, wr_en}, (g != 0));
    chk("wr_rd", {27'b0, wr_rd}, (g == 1) ? {27'b0, ma_rd} : (g == 2) ? {27'b0, mb_rd} : 0);
    chk("wr_data", wr_data, (g == 1) ? ma_data : (g == 2) ? mb_data : 0);
    chk("a_ready", {31'b0, a_ready}, {31'b0, ea});
    chk("b_ready", {31'b0, b_ready}, {31'b0, eb});
    lookup(q_rs1, p1, f1);
    lookup(q_rs2, p2, f2);
    chk("rs1_pend", {31'b0, rs1_pend}, {31'b0, p1});
    chk("rs1_fwd", rs1_fwd, f1);
    chk("rs2_pend", {31'b0, rs2_pend}, {31'b0, p2});
    chk("rs2_fwd", rs2_fwd, f2);
    if (g == 1) ma_full = 0;
    if (g == 2) mb_full = 0;
    if (a_valid && ea && a_rd != 0) begin
      ma_full = 1; ma_rd = a_rd; ma_data = a_data; ma_stamp = m_cyc;
    end
    if (b_valid && eb && b_rd != 0) begin
      mb_full = 1; mb_rd = b_rd; mb_data = b_data; mb_stamp = m_cyc;
    end
    m_cyc++;
  endtask

  initial begin
    //            av ard  adat          bv brd  bdat  q1 q2  wen wrd wdat          ar br p1 f1            p2 f2
    vecs[0]  = '{1, 5,  32'hDEAD_BEEF, 0, 0,  0,    5, 0,  0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[1]  = '{1, 0,  32'hFFFF_FFFF, 0, 0,  0,    0, 5,  1, 5,  32'hDEAD_BEEF, 1, 1, 0, 0,            1, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 9,  32'h1234,      0, 0,  0,    0, 9,  0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[3]  = '{0, 0,  0,             0, 0,  0,    9, 9,  1, 9,  32'h1234,     1, 1, 1, 32'h1234,     1, 32'h1234};
    vecs[4]  = '{0, 0,  0,             0, 0,  0,    9, 9,  0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[5]  = '{1, 3,  32'h33,        1, 4,  32'h44, 3, 4, 0, 0, 0,            1, 1, 0, 0,            0, 0};
    vecs[6]  = '{1, 10, 32'hA0,        1, 11, 32'hB0, 3, 4, 1, 3, 32'h33,       1, 0, 1, 32'h33,       1, 32'h44};
    vecs[7]  = '{1, 12, 32'hC0,        1, 11, 32'hB0, 10, 4, 1, 4, 32'h44,      0, 1, 1, 32'hA0,       1, 32'h44};
    vecs[8]  = '{1, 12, 32'hC0,        1, 13, 32'hD0, 11, 12, 1, 10, 32'hA0,    1, 0, 1, 32'hB0,       0, 0};
    vecs[9]  = '{0, 0,  0,             0, 0,  0,    12, 11, 1, 11, 32'hB0,      0, 1, 1, 32'hC0,       1, 32'hB0};
    vecs[10] = '{0, 0,  0,             0, 0,  0,    12, 0, 1, 12, 32'hC0,       1, 1, 1, 32'hC0,       0, 0};
    vecs[11] = '{0, 0,  0,             0, 0,  0,    12, 0, 0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[12] = '{0, 0,  0,             1, 7,  32'h1, 7, 0, 0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[13] = '{1, 7,  32'h2,         0, 0,  0,    7, 0,  1, 7,  32'h1,        1, 1, 1, 32'h1,        0, 0};
    vecs[14] = '{0, 0,  0,             0, 0,  0,    7, 0,  1, 7,  32'h2,        1, 1, 1, 32'h2,        0, 0};
    vecs[15] = '{0, 0,  0,             0, 0,  0,    7, 0,  0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[16] = '{1, 3,  32'h33,        1, 7,  32'h1, 7, 0, 0, 0,  0,            1, 1, 0, 0,            0, 0};
    vecs[17] = '{1, 7,  32'h2,         0, 0,  0,    7, 3,  1, 3,  32'h33,       1, 0, 1, 32'h1,        1, 32'h33};
    vecs[18] = '{0, 0,  0,             0, 0,  0,    7, 0,  1, 7,  32'h1,        0, 1, 1, 32'h2,        0, 0};
    vecs[19] = '{0, 0,  0,             0, 0,  0,    7, 0,  1, 7,  32'h2,        1, 1, 1, 32'h2,        0, 0};
    vecs[20] = '{0, 0,  0,             0, 0,  0,    7, 0,  0, 0,  0,            1, 1, 0, 0,            0, 0};

    reset = 1; a_valid = 0; b_valid = 0; a_rd = '0; b_rd = '0;
    a_data = '0; b_data = '0; q_rs1 = '0; q_rs2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("por_wr_en", {31'b0, wr_en}, 0);
    chk("por_a_ready", {31'b0, a_ready}, 0);
    chk("por_b_ready", {31'b0, b_ready}, 0);
    @(negedge clk);
    reset = 0;

    // Directed table: each row's expectations hold in the cycle its inputs are applied.
    for (int i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].adat;
      b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bdat;
      q_rs1 = vecs[i].q1; q_rs2 = vecs[i].q2;
      #1;
      chk($sformatf("v%0d_wr_en", i), {31'b0, wr_en}, {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d_wr_rd", i), {27'b0, wr_rd}, {27'b0, vecs[i].e_wrd});
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wdat);
      chk($sformatf("v%0d_a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].e_ardy});
      chk($sformatf("v%0d_b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].e_brdy});
      chk($sformatf("v%0d_rs1_pend", i), {31'b0, rs1_pend}, {31'b0, vecs[i].e_p1});
      chk($sformatf("v%0d_rs1_fwd", i), rs1_fwd, vecs[i].e_f1);
      chk($sformatf("v%0d_rs2_pend", i), {31'b0, rs2_pend}, {31'b0, vecs[i].e_p2});
      chk($sformatf("v%0d_rs2_fwd", i), rs2_fwd, vecs[i].e_f2);
    end

    // Reset mid-operation with both slots full.
    @(negedge clk);
    a_valid = 1; a_rd = 1; a_data = 32'h11;
    b_valid = 1; b_rd = 2; b_data = 32'h22;
    q_rs1 = 2; q_rs2 = 1;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    #1;
    chk("mid_wr_en_before", {31'b0, wr_en}, 1);
    chk("mid_rs1_pend_before", {31'b0, rs1_pend}, 1);
    #2 reset = 1;
    #1;
    chk("mid_wr_en_rst", {31'b0, wr_en}, 0);
    chk("mid_a_ready_rst", {31'b0, a_ready}, 0);
    chk("mid_b_ready_rst", {31'b0, b_ready}, 0);
    chk("mid_rs1_pend_rst", {31'b0, rs1_pend}, 0);
    chk("mid_rs2_fwd_rst", rs2_fwd, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_a_ready_rel", {31'b0, a_ready}, 1);
    chk("mid_b_ready_rel", {31'b0, b_ready}, 1);
    chk("mid_wr_en_rel", {31'b0, wr_en}, 0);
    @(negedge clk);
    #1;
    chk("mid_wr_en_after", {31'b0, wr_en}, 0);
    chk("mid_rs2_pend_after", {31'b0, rs2_pend}, 0);

    // Random traffic with narrow address range to force collisions and x0 writes.
    model_clear();
    m_cyc = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 99) == 0);
      a_valid = $urandom_range(0, 3) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      a_rd    = ADDR_W'($urandom_range(0, 3));
      b_rd    = ADDR_W'($urandom_range(0, 3));
      a_data  = $urandom;
      b_data  = $urandom;
      q_rs1   = ADDR_W'($urandom_range(0, 3));
      q_rs2   = ADDR_W'($urandom_range(0, 3));
      #1;
      model_step();
    end
    @(negedge clk);
    reset = 0; a_valid = 0; b_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
